key_debounce_multi: RTL

//  Parametrised N-channel push-button debouncer; successor to the single-key debouncer.

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_multi_if.sv | 23 ++
 rtl/key_debounce_ch.sv | 115 +++++++++++
 rtl/key_debounce_multi.sv | 50 +++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types for the multi-key debouncer: one-hot channel state encoding and the
// normalised (1 = pressed) released level used for synchroniser reset.
package key_debounce_pkg;

  typedef enum logic [3:0] {
    IDLE          = 4'b0001,
    PRESS_DELAY   = 4'b0010,
    WAIT_RELEASE  = 4'b0100,
    RELEASE_DELAY = 4'b1000
  } state_t;

  localparam int   STATE_W      = 4;
  localparam logic KEY_RELEASED = 1'b0;

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key pins and per-channel debounced outputs, grouped for the debouncer boundary.
interface key_debounce_multi_if #(
  parameter int NUM_KEYS = 4
);
  // No valid/ready handshake here: key_in is a free-running raw level, key_vld is a level,
  // and key_press/key_release/key_long are single-cycle strobes meant to be sampled every clock.
  logic [NUM_KEYS-1:0]   key_in;
  logic [NUM_KEYS-1:0]   key_vld;
  logic [NUM_KEYS-1:0]   key_press;
  logic [NUM_KEYS-1:0]   key_release;
  logic [NUM_KEYS-1:0]   key_long;
  logic [4*NUM_KEYS-1:0] state;

  modport master (
    output key_in,
    input  key_vld, key_press, key_release, key_long, state
  );

  modport slave (
    input  key_in,
    output key_vld, key_press, key_release, key_long, state
  );
endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, IDLE/PRESS_DELAY/WAIT_RELEASE/RELEASE_DELAY FSM,
// registered level and strobes. Long-press counter present only with KEY_LONG_PRESS_EN.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DELAY_TIME = 18'h3ffff
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_TIME  = 24'hffffff
`endif
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   key,
  output logic   key_vld,
  output logic   key_press,
  output logic   key_release,
  output logic   key_long,
  output state_t state
);

  localparam int             CNT_W   = $clog2(DELAY_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY_TIME);

  logic             sync1, sync2;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_d, press_d, release_d;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= KEY_RELEASED;
      sync2       <= KEY_RELEASED;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_vld     <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync1       <= key;
      sync2       <= sync1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_vld     <= vld_d;
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

  // Counter only advances inside the delay states; any other path leaves it cleared.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    vld_d     = key_vld;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2) state_d = PRESS_DELAY;
      end
      PRESS_DELAY: begin
        if (!sync2) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = WAIT_RELEASE;
          press_d = 1'b1;
          vld_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!sync2) state_d = RELEASE_DELAY;
      end
      RELEASE_DELAY: begin
        if (sync2) begin
          state_d = WAIT_RELEASE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          release_d = 1'b1;
          vld_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int              LONG_W   = $clog2(LONG_TIME + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TIME);
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_TIME - 1);

  logic [LONG_W-1:0] long_cnt;

  // Counts only while the key is accepted as held; saturation yields one strobe per press.
  always_ff @(posedge clk) begin
    if (rst || state_q == IDLE || state_q == PRESS_DELAY) begin
      long_cnt <= '0;
      key_long <= 1'b0;
    end else if (long_cnt != LONG_MAX) begin
      long_cnt <= long_cnt + 1'b1;
      key_long <= (long_cnt == LONG_PRE);
    end else begin
      key_long <= 1'b0;
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// N-channel push-button debouncer: polarity normalisation plus one key_debounce_ch per key.
// Optional long-press strobe enabled by defining KEY_LONG_PRESS_EN.
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS   = 4,
  parameter int DELAY_TIME = 18'h3ffff,
  parameter int ACTIVE_LOW = 1
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_TIME  = 24'hffffff
`endif
) (
  input logic                  clk,
  input logic                  rst,
  key_debounce_multi_if.slave  keys
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    logic   pressed;
    logic   vld, prs, rls, lng;
    state_t st;

    assign pressed = (ACTIVE_LOW != 0) ? ~keys.key_in[i] : keys.key_in[i];

    key_debounce_ch #(
      .DELAY_TIME (DELAY_TIME)
`ifdef KEY_LONG_PRESS_EN
      ,
      .LONG_TIME  (LONG_TIME)
`endif
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key         (pressed),
      .key_vld     (vld),
      .key_press   (prs),
      .key_release (rls),
      .key_long    (lng),
      .state       (st)
    );

    assign keys.key_vld[i]                 = vld;
    assign keys.key_press[i]               = prs;
    assign keys.key_release[i]             = rls;
    assign keys.key_long[i]                = lng;
    assign keys.state[STATE_W*i +: STATE_W] = st;
  end

endmodule
